// File: rtl/final_bits_flush_serializer.sv
// rtl/final_bits_flush_serializer.sv - range-coder final-bits flush, one precarry word per accepted beat
module final_bits_flush_serializer #(
  parameter int OUTPUT_BITSTREAM_WIDTH = 16,
  parameter int D_SIZE                 = 5,
  parameter int LOW_WIDTH              = 24,
  parameter int MAX_WORDS              = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_start,
  input  logic [D_SIZE-1:0]                 in_cnt,
  input  logic [LOW_WIDTH-1:0]              in_low,
  input  logic                              in_ready,
  output logic                              out_valid,
  output logic [OUTPUT_BITSTREAM_WIDTH-1:0] out_bit,
  output logic                              out_last,
  output logic                              out_busy,
  output logic                              out_done,
  output logic [$clog2(MAX_WORDS+1)-1:0]    out_word_count
);

  localparam int EW   = LOW_WIDTH + 1;
  localparam int CW   = D_SIZE + 2;
  localparam int CNTW = $clog2(MAX_WORDS + 1);

  localparam logic [EW-1:0]        M_MASK = EW'((1 << 14) - 1);
  localparam logic [EW-1:0]        E_ONE  = EW'(1);
  localparam logic signed [CW-1:0] C8     = CW'(8);
  localparam logic signed [CW-1:0] C10    = CW'(10);
  localparam logic signed [CW-1:0] C16    = CW'(16);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t                 r_state;
  logic [EW-1:0]          r_e;
  logic [EW-1:0]          r_n;
  logic signed [CW-1:0]   r_c;
  logic signed [CW-1:0]   r_s;

  logic signed [CW-1:0]   w_c0;
  logic signed [CW-1:0]   w_s0;
  logic signed [CW-1:0]   w_sh0;
  logic [EW-1:0]          w_e0;
  logic [EW-1:0]          w_n0;
  logic [EW-1:0]          w_word0;
  logic signed [CW-1:0]   w_s0_m8;

  logic [EW-1:0]          w_e_nx;
  logic signed [CW-1:0]   w_c_nx;
  logic signed [CW-1:0]   w_s_nx;
  logic signed [CW-1:0]   w_sh_nx;
  logic signed [CW-1:0]   w_s_nx_m8;
  logic [EW-1:0]          w_word_nx;
  logic                   w_accept;

  // Rounding of low is done one bit wider so a carry out of the top is kept.
  assign w_c0    = {{(CW-D_SIZE){in_cnt[D_SIZE-1]}}, in_cnt};
  assign w_s0    = w_c0 + C10;
  assign w_sh0   = w_c0 + C16;
  assign w_e0    = ((EW'(in_low) + M_MASK) & ~M_MASK) | (M_MASK + E_ONE);
  assign w_n0    = (E_ONE << unsigned'(w_sh0)) - E_ONE;
  assign w_word0 = w_e0 >> unsigned'(w_sh0);
  assign w_s0_m8 = w_s0 - C8;

  assign w_accept  = out_valid & in_ready;
  assign w_e_nx    = r_e & r_n;
  assign w_c_nx    = r_c - C8;
  assign w_s_nx    = r_s - C8;
  assign w_sh_nx   = w_c_nx + C16;
  assign w_s_nx_m8 = w_s_nx - C8;
  assign w_word_nx = w_e_nx >> unsigned'(w_sh_nx);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_e            <= '0;
      r_n            <= '0;
      r_c            <= '0;
      r_s            <= '0;
      out_valid      <= 1'b0;
      out_bit        <= '0;
      out_last       <= 1'b0;
      out_busy       <= 1'b0;
      out_done       <= 1'b0;
      out_word_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          out_done <= 1'b0;
          if (in_start) begin
            out_word_count <= '0;
            out_busy       <= 1'b1;
            r_e            <= w_e0;
            r_n            <= w_n0;
            r_c            <= w_c0;
            r_s            <= w_s0;
            if (w_s0 > 0) begin
              r_state   <= S_EMIT;
              out_valid <= 1'b1;
              out_bit   <= w_word0[OUTPUT_BITSTREAM_WIDTH-1:0];
              out_last  <= (w_s0_m8 <= 0);
            end else begin
              r_state  <= S_DONE;
              out_done <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (w_accept) begin
            out_word_count <= out_word_count + CNTW'(1);
            if (out_last) begin
              r_state   <= S_DONE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_bit   <= '0;
              out_done  <= 1'b1;
            end else begin
              r_e      <= w_e_nx;
              r_n      <= r_n >> 8;
              r_c      <= w_c_nx;
              r_s      <= w_s_nx;
              out_bit  <= w_word_nx[OUTPUT_BITSTREAM_WIDTH-1:0];
              out_last <= (w_s_nx_m8 <= 0);
            end
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          out_done <= 1'b0;
          out_busy <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_final_bits_flush_serializer.sv
// tb/tb_final_bits_flush_serializer.sv - scoreboard bench for the final-bits flush serializer
module tb_final_bits_flush_serializer;

  logic        clk;
  logic        reset;
  logic        in_start;
  logic [4:0]  in_cnt;
  logic [23:0] in_low;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_bit;
  logic        out_last;
  logic        out_busy;
  logic        out_done;
  logic [1:0]  out_word_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        last;
    logic [15:0] word;
  } exp_t;

  exp_t exp_q[$];

  final_bits_flush_serializer #(
    .OUTPUT_BITSTREAM_WIDTH(16), .D_SIZE(5), .LOW_WIDTH(24), .MAX_WORDS(3)
  ) dut (
    .clk(clk), .reset(reset), .in_start(in_start), .in_cnt(in_cnt), .in_low(in_low),
    .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last),
    .out_busy(out_busy), .out_done(out_done), .out_word_count(out_word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: word j is bits [sh+7:sh] of the rounded low (whole upper part for j=0).
  function automatic int push_expected(input int cnt, input logic [23:0] low);
    logic [24:0] m, e, w;
    int s, k, sh;
    m = 25'h3FFF;
    e = ((25'(low) + m) & ~m) | 25'h4000;
    s = cnt + 10;
    k = (s > 0) ? (s + 7) / 8 : 0;
    for (int j = 0; j < k; j++) begin
      exp_t x;
      sh = cnt + 16 - 8 * j;
      w  = e >> sh;
      if (j > 0) w = w & 25'hFF;
      x.last = (j == k - 1);
      x.word = w[15:0];
      exp_q.push_back(x);
    end
    return k;
  endfunction

  // stall_mode: 0 ready always, 3 hold ready low 3 cycles per word, -1 random ready
  task automatic run_flush(input string name, input int cnt, input logic [23:0] low,
                           input int stall_mode, input bit poke);
    int k, got, stalls, iters;
    bit seen_done;
    k = push_expected(cnt, low);
    got = 0; stalls = 0; iters = 0; seen_done = 0;
    @(negedge clk);
    in_start = 1'b1; in_cnt = 5'(cnt); in_low = low; in_ready = 1'b0;
    @(negedge clk);
    in_start = 1'b0;
    in_cnt = 5'(cnt + 3); in_low = ~low;
    while (iters < 200) begin
      if (poke) in_start = (iters == 0);
      if (out_done) begin
        seen_done = 1;
        break;
      end
      if (!out_valid) begin
        chk({name, " bubble"}, {31'd0, out_valid}, 32'd1);
      end else begin
        if (stall_mode == 3) in_ready = (stalls >= 3);
        else if (stall_mode < 0) in_ready = 1'($urandom_range(0, 1));
        else in_ready = 1'b1;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $error("FAIL %s extra_word observed=0x%0h expected=none", name, out_bit);
        end else if (!in_ready) begin
          stalls++;
          chk({name, " hold_word"}, {16'd0, out_bit}, {16'd0, exp_q[0].word});
          chk({name, " hold_last"}, {31'd0, out_last}, {31'd0, exp_q[0].last});
        end else begin
          exp_t x;
          x = exp_q.pop_front();
          stalls = 0;
          got++;
          chk({name, " word"}, {16'd0, out_bit}, {16'd0, x.word});
          chk({name, " last"}, {31'd0, out_last}, {31'd0, x.last});
        end
      end
      iters++;
      @(negedge clk);
    end
    in_start = 1'b0;
    in_ready = 1'b0;
    if (!seen_done) begin
      checks++; errors++;
      $error("FAIL %s timeout observed=no_done expected=done", name);
    end else begin
      chk({name, " words_seen"}, got, k);
      if (stall_mode == 0) chk({name, " latency"}, iters, k);
      chk({name, " count"}, {30'd0, out_word_count}, k);
      chk({name, " busy_in_done"}, {31'd0, out_busy}, 32'd1);
      chk({name, " valid_in_done"}, {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      chk({name, " done_pulse"}, {31'd0, out_done}, 32'd0);
      chk({name, " busy_idle"}, {31'd0, out_busy}, 32'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    reset = 1'b0; in_start = 1'b0; in_cnt = '0; in_low = '0; in_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", {31'd0, out_valid}, 32'd0);
    chk("rst bit", {16'd0, out_bit}, 32'd0);
    chk("rst last", {31'd0, out_last}, 32'd0);
    chk("rst busy", {31'd0, out_busy}, 32'd0);
    chk("rst done", {31'd0, out_done}, 32'd0);
    chk("rst count", {30'd0, out_word_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    run_flush("cnt-10", -10, 24'h000000, 0, 0);
    run_flush("cnt-9", -9, 24'h000000, 0, 0);
    run_flush("cnt0", 0, 24'h123456, 0, 0);
    run_flush("cnt7", 7, 24'hFFFFFF, 0, 0);
    run_flush("cnt7_stall", 7, 24'hFFFFFF, 3, 0);
    run_flush("cnt0_poke", 0, 24'h123456, 0, 1);
    run_flush("cnt-16", -16, 24'hABCDEF, 0, 0);
    run_flush("cnt-2", -2, 24'h0F3FFF, 3, 0);

    for (int r = 0; r < 24; r++) begin
      int cnt;
      cnt = int'($urandom_range(0, 23)) - 16;
      run_flush("rand", cnt, 24'($urandom), -1, 0);
    end

    @(negedge clk);
    in_start = 1'b1; in_cnt = 5'd7; in_low = 24'hFFFFFF; in_ready = 1'b1;
    @(negedge clk);
    in_start = 1'b0;
    chk("abort w0", {16'd0, out_bit}, 32'h0002);
    @(negedge clk);
    chk("abort w1_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b0; in_ready = 1'b0;
    @(negedge clk);
    chk("abort valid", {31'd0, out_valid}, 32'd0);
    chk("abort bit", {16'd0, out_bit}, 32'd0);
    chk("abort last", {31'd0, out_last}, 32'd0);
    chk("abort busy", {31'd0, out_busy}, 32'd0);
    chk("abort done", {31'd0, out_done}, 32'd0);
    chk("abort count", {30'd0, out_word_count}, 32'd0);
    reset = 1'b1; in_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort stays_idle", {31'd0, out_valid | out_busy}, 32'd0);

    run_flush("after_abort", 0, 24'h123456, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
